// File: rtl/uart_pkg.sv
// Shared UART constants used by the receive buffer and, later, the transmit side.
//   UART_DATA_W      : width of one UART character
//   UART_RXBUF_DEPTH : default number of entries in the receive FIFO
package uart_pkg;

  localparam int UART_DATA_W      = 8;
  localparam int UART_RXBUF_DEPTH = 8;

endpackage

// File: rtl/uart_rx_buffer_if.sv
// Bus between the UART receiver / CPU controller and the receive buffer.
//   rx_data, rx_status : byte and "byte done" strobe from the receiver
//   rd_en, ovr_clr     : CPU pop request and overrun clear
//   rd_data, empty, full, count, overrun, irq : buffer status towards the CPU
// The slave modport is the buffer; the master modport is its environment.
interface uart_rx_buffer_if #(
  parameter int ADDR_W = 3
);
  import uart_pkg::*;

  logic [UART_DATA_W-1:0] rx_data;
  logic                   rx_status;
  logic                   rd_en;
  logic                   ovr_clr;
  logic [UART_DATA_W-1:0] rd_data;
  logic                   empty;
  logic                   full;
  logic [ADDR_W:0]        count;
  logic                   overrun;
  logic                   irq;

  modport slave (
    input  rx_data, rx_status, rd_en, ovr_clr,
    output rd_data, empty, full, count, overrun, irq
  );

  modport master (
    output rx_data, rx_status, rd_en, ovr_clr,
    input  rd_data, empty, full, count, overrun, irq
  );

endinterface

// File: rtl/uart_pulse_sync.sv
// Brings an asynchronous level/strobe into the clk domain and emits a single
// clk-cycle pulse on its rising edge.
//   clk      : destination clock
//   reset    : asynchronous active-high reset, clears all stages
//   async_in : asynchronous input (held high for at least 2 clk periods)
//   pulse    : one-cycle pulse per rising edge of async_in
module uart_pulse_sync (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic pulse
);

  // s1/s2 form the metastability synchronizer, s3 remembers the previous
  // synchronized level for edge detection.
  logic s1_reg;
  logic s2_reg;
  logic s3_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_reg <= 1'b0;
      s2_reg <= 1'b0;
      s3_reg <= 1'b0;
    end else begin
      s1_reg <= async_in;
      s2_reg <= s1_reg;
      s3_reg <= s2_reg;
    end
  end

  assign pulse = s2_reg & ~s3_reg;

endmodule

// File: rtl/uart_rx_buffer.sv
// Receive-side buffer behind the UART receiver. Each completed byte (rising
// edge of rx_status, synchronized into clk) is written into a small
// first-word-fall-through FIFO that the CPU drains with rd_en.
//   clk   : system clock
//   reset : asynchronous active-high reset; discards buffered bytes
//   bus   : slave side of uart_rx_buffer_if (receiver inputs, CPU status)
// Parameters: DEPTH entries (power of two, >= 2), ADDR_W = log2(DEPTH).
module uart_rx_buffer
  import uart_pkg::*;
#(
  parameter int DEPTH  = UART_RXBUF_DEPTH,
  parameter int ADDR_W = 3
) (
  input  logic            clk,
  input  logic            reset,
  uart_rx_buffer_if.slave bus
);

  localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W + 1)'(DEPTH);

  logic                   push;
  logic                   pop;
  logic                   push_ok;
  logic                   drop;
  logic [UART_DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0]      wr_ptr_reg;
  logic [ADDR_W-1:0]      rd_ptr_reg;
  logic [ADDR_W:0]        count_reg;
  logic [ADDR_W:0]        count_next;
  logic                   overrun_reg;

  uart_pulse_sync u_sync (
    .clk      (clk),
    .reset    (reset),
    .async_in (bus.rx_status),
    .pulse    (push)
  );

  // rx_data is held stable across the whole strobe and beyond, so it is
  // sampled directly on the push cycle without its own synchronizer.
  assign pop     = bus.rd_en & (count_reg != '0);
  // A push into a full FIFO still fits when the head leaves in the same cycle.
  assign push_ok = push & ((count_reg != FULL_COUNT) | pop);
  assign drop    = push & ~push_ok;

  always_comb begin
    count_next = count_reg;
    unique case ({push_ok, pop})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  // Storage has no reset; only pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_reg] <= bus.rx_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      count_reg   <= '0;
      overrun_reg <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      count_reg <= count_next;
      // A drop in the same cycle as a clear leaves the flag set.
      if (drop) begin
        overrun_reg <= 1'b1;
      end else if (bus.ovr_clr) begin
        overrun_reg <= 1'b0;
      end
    end
  end

  // Show-ahead head entry; status flags decode only registered state.
  assign bus.rd_data = mem[rd_ptr_reg];
  assign bus.count   = count_reg;
  assign bus.empty   = (count_reg == '0);
  assign bus.full    = (count_reg == FULL_COUNT);
  assign bus.irq     = (count_reg != '0);
  assign bus.overrun = overrun_reg;

endmodule

// File: tb/tb_uart_rx_buffer.sv
// Directed bench for uart_rx_buffer with a queue-based reference model that
// is compared against the outputs on every falling clock edge.
module tb_uart_rx_buffer;

  localparam int DEPTH  = 8;
  localparam int ADDR_W = 3;

  logic clk;
  logic reset;

  uart_rx_buffer_if #(.ADDR_W(ADDR_W)) bus ();

  uart_rx_buffer #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a byte becomes visible two edges after the first edge
  // that sees the strobe high; the FIFO itself is a plain queue.
  byte unsigned mq[$];
  int           due_q[$];
  bit           m_ovr  = 1'b0;
  bit           m_prev = 1'b0;
  int           m_cyc  = 0;
  bit           m_push;
  bit           m_pop;
  bit           m_drop;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mq.delete();
      due_q.delete();
      m_ovr  = 1'b0;
      m_prev = 1'b0;
    end else begin
      m_push = (due_q.size() > 0) && (due_q[0] == m_cyc);
      if (m_push) void'(due_q.pop_front());
      if (bus.rx_status && !m_prev) due_q.push_back(m_cyc + 2);
      m_prev = bus.rx_status;
      m_pop  = bus.rd_en && (mq.size() > 0);
      m_drop = m_push && (mq.size() == DEPTH) && !m_pop;
      if (m_pop) void'(mq.pop_front());
      if (m_push && !m_drop) mq.push_back(bus.rx_data);
      if (m_drop) m_ovr = 1'b1;
      else if (bus.ovr_clr) m_ovr = 1'b0;
      m_cyc++;
    end
  end

  always @(negedge clk) begin
    chk("model_count", int'(bus.count), mq.size());
    chk("model_empty", int'(bus.empty), int'(mq.size() == 0));
    chk("model_full", int'(bus.full), int'(mq.size() == DEPTH));
    chk("model_irq", int'(bus.irq), int'(mq.size() != 0));
    chk("model_overrun", int'(bus.overrun), int'(m_ovr));
    if (mq.size() > 0) chk("model_rd_data", int'(bus.rd_data), int'(mq[0]));
  end

  task automatic strobe(input logic [7:0] d);
    $display("strobe rx_data=0x%02h", d);
    bus.rx_data   = d;
    bus.rx_status = 1'b1;
    repeat (3) @(negedge clk);
    bus.rx_status = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic do_pop();
    $display("pop rd_data=0x%02h count=%0d", bus.rd_data, bus.count);
    bus.rd_en = 1'b1;
    @(negedge clk);
    bus.rd_en = 1'b0;
  endtask

  initial begin
    logic [7:0] exp_b;
    reset         = 1'b0;
    bus.rx_status = 1'b0;
    bus.rx_data   = 8'h00;
    bus.rd_en     = 1'b0;
    bus.ovr_clr   = 1'b0;
    #1 reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_empty", int'(bus.empty), 1);
    chk("rst_full", int'(bus.full), 0);
    chk("rst_count", int'(bus.count), 0);
    chk("rst_overrun", int'(bus.overrun), 0);
    chk("rst_irq", int'(bus.irq), 0);
    reset = 1'b0;
    @(negedge clk);

    // Single long strobe: exactly one push, visible after the third edge.
    $display("strobe rx_data=0x5a (held 16 cycles)");
    bus.rx_data   = 8'h5A;
    bus.rx_status = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("lat_e1_empty", int'(bus.empty), 1);
    @(negedge clk);
    chk("lat_e2_empty", int'(bus.empty), 0);
    chk("lat_rd_data", int'(bus.rd_data), 8'h5A);
    chk("lat_count", int'(bus.count), 1);
    chk("lat_irq", int'(bus.irq), 1);
    repeat (13) @(negedge clk);
    bus.rx_status = 1'b0;
    chk("hold_count", int'(bus.count), 1);
    do_pop();
    chk("pop1_empty", int'(bus.empty), 1);

    // Fill to full, then overflow with 0xFF.
    for (int i = 1; i <= 8; i++) strobe(8'(i));
    chk("fill_full", int'(bus.full), 1);
    chk("fill_count", int'(bus.count), 8);
    strobe(8'hFF);
    chk("ovr_set", int'(bus.overrun), 1);
    chk("ovr_count", int'(bus.count), 8);
    chk("ovr_head", int'(bus.rd_data), 8'h01);
    bus.ovr_clr = 1'b1;
    @(negedge clk);
    bus.ovr_clr = 1'b0;
    chk("ovr_clr", int'(bus.overrun), 0);

    // Push edge coincides with a pop while full.
    $display("strobe rx_data=0x99 with coincident pop");
    bus.rx_data   = 8'h99;
    bus.rx_status = 1'b1;
    @(negedge clk);
    @(negedge clk);
    bus.rd_en = 1'b1;
    @(negedge clk);
    bus.rd_en = 1'b0;
    chk("pp_count", int'(bus.count), 8);
    chk("pp_overrun", int'(bus.overrun), 0);
    chk("pp_head", int'(bus.rd_data), 8'h02);
    bus.rx_status = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      exp_b = (i < 7) ? 8'(i + 2) : 8'h99;
      chk("drain_data", int'(bus.rd_data), int'(exp_b));
      do_pop();
    end
    chk("drain_empty", int'(bus.empty), 1);

    // Pop while empty is ignored.
    do_pop();
    chk("epop_count", int'(bus.count), 0);
    strobe(8'h33);
    chk("epop_data", int'(bus.rd_data), 8'h33);
    chk("epop_count1", int'(bus.count), 1);
    do_pop();

    // Reset mid-stream with a strobe still high at release.
    strobe(8'hA1);
    strobe(8'hA2);
    strobe(8'hA3);
    chk("mid_count", int'(bus.count), 3);
    bus.rx_data   = 8'hC4;
    bus.rx_status = 1'b1;
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    $display("async reset asserted");
    chk("arst_empty", int'(bus.empty), 1);
    chk("arst_count", int'(bus.count), 0);
    chk("arst_overrun", int'(bus.overrun), 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    chk("rel_count", int'(bus.count), 1);
    chk("rel_data", int'(bus.rd_data), 8'hC4);
    bus.rx_status = 1'b0;
    repeat (3) @(negedge clk);
    chk("rel_count_hold", int'(bus.count), 1);
    strobe(8'h77);
    chk("post_count", int'(bus.count), 2);
    do_pop();
    chk("post_data", int'(bus.rd_data), 8'h77);
    do_pop();
    chk("post_empty", int'(bus.empty), 1);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
